axi_read_arbiter: RTL and testbench
===================================

# axi_read_arbiter

Shares the single AXI read channel (AR/R) between the instruction-side and data-side requesters of the CPU bus interface. Arbitrates round-robin, tags each AR with a per-requester ID and routes R beats back by ID. Caps outstanding reads per requester and stalls reads that hit a pending write. Sits between the CPU's SRAM-like request ports and the AXI crossbar, beside the write-channel logic that drives `write_pending`/`write_address`.

## Interface
Parameters:
- `MAX_OUTSTANDING`, 2: max in-flight reads per requester, 1..15.
- `INST_ID`, 4'd0: ARID/RID for instruction reads.
- `DATA_ID`, 4'd1: ARID/RID for data reads; must differ from `INST_ID`.

Ports:
- Reset: one clock; reset is asynchronous and active-high (`clock`, `reset`).
- `clock`  in  1  system clock.
- `reset`  in  1  async active-high reset.
- `inst_req` / `data_req`  in  1  read request valid.
- `inst_addr` / `data_addr`  in  32  byte address.
- `inst_size` / `data_size`  in  2  log2 bytes (0/1/2).
- `inst_addr_ok` / `data_addr_ok`  out  1  request accepted this cycle.
- `inst_data_ok` / `data_data_ok`  out  1  read data valid this cycle.
- `inst_rdata` / `data_rdata`  out  32  read data.
- `write_pending`  in  1  a data write is in flight on AW/W/B.
- `write_address`  in  32  address of that write.
- `axi_read_address_id`  out  4; `axi_read_address`  out  32; `axi_read_address_length`  out  8 (const 0); `axi_read_address_size`  out  3 ({1'b0,size}); `axi_read_address_burst`  out  2 (const 2'b01); `axi_read_address_valid`  out  1; `axi_read_address_ready`  in  1.
- `axi_read_data_id`  in  4; `axi_read_data`  in  32; `axi_read_data_response`  in  2; `axi_read_data_last`  in  1; `axi_read_data_valid`  in  1; `axi_read_data_ready`  out  1.
- `error`  out  1  sticky protocol/response error flag.

## Operation
- Hazard: requester X is blocked when `write_pending && X_addr[31:2] == write_address[31:2]`.
- Eligible(X) = `X_req && count_X < MAX_OUTSTANDING && !hazard(X)`.
- Slot free = `!axi_read_address_valid || axi_read_address_ready`.
- Grant: if slot free and exactly one requester is eligible, that one wins. If both are eligible, the requester not granted last wins. The `last_grant` register resets to INST, so DATA wins the first tie.
- On grant: `X_addr_ok`=1 combinationally that cycle. AR regs capture addr, size and ID at the clock edge; `axi_read_address_valid`<=1; `count_X`++; `last_grant`<=X.
- Slot free with no grant: `axi_read_address_valid`<=0.
- While `axi_read_address_valid && !axi_read_address_ready`, all AR outputs stay stable and every `addr_ok` is 0.
- `axi_read_data_ready` = `!reset` (always accepts).
- R routing (combinational): `X_data_ok` = `axi_read_data_valid && axi_read_data_id == X_ID`; both `rdata` outputs = `axi_read_data`.
- R completion: beat with `last` and a matching ID decrements `count_X`.
- Counter width is $clog2(MAX_OUTSTANDING+1). Same-cycle issue and completion on one requester leaves the count unchanged.
- `error` sets, and holds until reset, on any of:
  - RID matching neither ID (no data_ok asserted);
  - RID matching with `count_X`==0 (data_ok still asserted, no decrement);
  - `axi_read_data_response` != 0 (data still delivered).

## Timing
- Reset values:
  - `axi_read_address_valid`=0 and all AR regs 0.
  - All counts 0, `error`=0, `last_grant`=INST.
  - `axi_read_data_ready`=0; `addr_ok`/`data_ok` are 0 by construction.
- Reset mid-operation discards in-flight bookkeeping; the interconnect is reset with the same signal.
- Issue latency: request accepted in cycle N gives ARVALID high in N+1. Back-to-back accepts are possible every cycle while ARREADY=1.
- Return latency: R beat to `data_ok` is 0 cycles (combinational).
- Requesters must hold req/addr/size until `addr_ok`. Requesters must accept `data_ok` unconditionally.
- Full: with `count_X`==MAX, X is not granted even if the slot is free. X becomes eligible the cycle after its completing beat; a same-cycle completion does not unblock.
- Hazard is evaluated combinationally each cycle. A hazard clearing at cycle N allows a grant in N.

## Test plan
- Single inst read 0x1FC0_0000, ARREADY=1, RVALID id0 data 0xDEADBEEF two cycles later -> `inst_addr_ok` cycle 0, ARVALID/ARID=0 cycle 1, `inst_data_ok` with 0xDEADBEEF, count back to 0.
- Both requesters hold req continuously, ARREADY=1 -> grants alternate DATA, INST, DATA, INST. With MAX=2 and no R returns, each gets exactly 2 grants, then both `addr_ok` stay 0.
- ARREADY held low 5 cycles with ARVALID up -> ARADDR/ARID/ARSIZE unchanged, no `addr_ok`. Raising ARREADY lets the next grant occur in the same cycle.
- `write_pending`=1, `write_address`=0x8000_0010, data read 0x8000_0012 -> blocked while inst read 0x8000_0100 proceeds. Dropping `write_pending` grants data in that cycle.
- Out-of-order R: data (id1) returns before inst (id0) -> correct `data_ok` routing, counts decrement independently.
- RID=4'd7 beat, then id0 beat with OKAY while inst count is 0 -> `error` rises after the first and stays 1; no counter underflows.

Source files
------------

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter
//
// Shares one AXI read channel (AR/R) between the instruction-side and data-side
// SRAM-like read ports of the CPU bus interface.
//   - Round-robin grant between the two requesters; each AR carries a fixed
//     per-requester ID and R beats are routed back by RID.
//   - Per-requester outstanding-read counters cap in-flight reads.
//   - A read whose word address matches an in-flight data write is held off.
//   - Sticky error flag for unknown RID, RID with nothing outstanding, or a
//     non-OKAY read response.
//
// Ports
//   clock, reset                 system clock, async active-high reset
//   inst_* / data_*              requester ports (req/addr/size in, addr_ok/data_ok/rdata out)
//   write_pending, write_address in-flight write from the write-channel logic
//   axi_read_address_*           AXI AR channel (master side)
//   axi_read_data_*              AXI R channel (master side)
//   error                        sticky protocol/response error
module axi_read_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [3:0]  INST_ID         = 4'd0,
    parameter logic [3:0]  DATA_ID         = 4'd1
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic [1:0]  inst_size,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic [31:0] data_addr,
    input  logic [1:0]  data_size,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    input  logic        write_pending,
    input  logic [31:0] write_address,

    output logic [3:0]  axi_read_address_id,
    output logic [31:0] axi_read_address,
    output logic [7:0]  axi_read_address_length,
    output logic [2:0]  axi_read_address_size,
    output logic [1:0]  axi_read_address_burst,
    output logic        axi_read_address_valid,
    input  logic        axi_read_address_ready,

    input  logic [3:0]  axi_read_data_id,
    input  logic [31:0] axi_read_data,
    input  logic [1:0]  axi_read_data_response,
    input  logic        axi_read_data_last,
    input  logic        axi_read_data_valid,
    output logic        axi_read_data_ready,

    output logic        error
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    typedef enum logic {
        LastInst,
        LastData
    } last_grant_e;

    last_grant_e last_grant_q, last_grant_d;

    logic [CW-1:0] inst_count_q, inst_count_d;
    logic [CW-1:0] data_count_q, data_count_d;

    logic [3:0]  arid_q, arid_d;
    logic [31:0] araddr_q, araddr_d;
    logic [2:0]  arsize_q, arsize_d;
    logic        arvalid_q, arvalid_d;

    logic error_q, error_d;

    logic hazard_inst, hazard_data;
    logic elig_inst, elig_data;
    logic slot_free;
    logic grant_inst, grant_data;
    logic r_inst, r_data;
    logic done_inst, done_data;
    logic err_now;

    // Byte-lane bits of the write address are irrelevant to the word match.
    logic unused_write_lanes;
    assign unused_write_lanes = ^write_address[1:0];

    // ------------------------------------------------------------------
    // Request side: hazard, eligibility, round-robin grant
    // ------------------------------------------------------------------
    assign hazard_inst = write_pending && (inst_addr[31:2] == write_address[31:2]);
    assign hazard_data = write_pending && (data_addr[31:2] == write_address[31:2]);

    assign elig_inst = inst_req && (inst_count_q < MAX_CNT) && !hazard_inst;
    assign elig_data = data_req && (data_count_q < MAX_CNT) && !hazard_data;

    // AR register may be reloaded when empty or being consumed this cycle.
    assign slot_free = !arvalid_q || axi_read_address_ready;

    // On a tie the requester not granted last time wins.
    assign grant_inst = slot_free && elig_inst && (!elig_data || last_grant_q == LastData);
    assign grant_data = slot_free && elig_data && (!elig_inst || last_grant_q == LastInst);

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;

    // ------------------------------------------------------------------
    // Response side: routing by RID, completion, error detection
    // ------------------------------------------------------------------
    assign r_inst = axi_read_data_valid && (axi_read_data_id == INST_ID);
    assign r_data = axi_read_data_valid && (axi_read_data_id == DATA_ID);

    assign inst_data_ok = r_inst;
    assign data_data_ok = r_data;
    assign inst_rdata   = axi_read_data;
    assign data_rdata   = axi_read_data;

    // A completion with nothing outstanding is flagged but never decrements.
    assign done_inst = r_inst && axi_read_data_last && (inst_count_q != '0);
    assign done_data = r_data && axi_read_data_last && (data_count_q != '0);

    assign err_now = axi_read_data_valid &&
                     ((!r_inst && !r_data) ||
                      (r_inst && inst_count_q == '0) ||
                      (r_data && data_count_q == '0) ||
                      (axi_read_data_response != 2'b00));

    assign axi_read_data_ready = !reset;

    // ------------------------------------------------------------------
    // AR channel outputs
    // ------------------------------------------------------------------
    assign axi_read_address_id     = arid_q;
    assign axi_read_address        = araddr_q;
    assign axi_read_address_length = 8'd0;
    assign axi_read_address_size   = arsize_q;
    assign axi_read_address_burst  = 2'b01;
    assign axi_read_address_valid  = arvalid_q;
    assign error                   = error_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        arid_d       = arid_q;
        araddr_d     = araddr_q;
        arsize_d     = arsize_q;
        arvalid_d    = arvalid_q;
        last_grant_d = last_grant_q;

        if (grant_inst) begin
            arid_d       = INST_ID;
            araddr_d     = inst_addr;
            arsize_d     = {1'b0, inst_size};
            arvalid_d    = 1'b1;
            last_grant_d = LastInst;
        end else if (grant_data) begin
            arid_d       = DATA_ID;
            araddr_d     = data_addr;
            arsize_d     = {1'b0, data_size};
            arvalid_d    = 1'b1;
            last_grant_d = LastData;
        end else if (slot_free) begin
            arvalid_d    = 1'b0;
        end
    end

    // Issue and completion in the same cycle cancel out.
    always_comb begin
        inst_count_d = inst_count_q;
        if (grant_inst && !done_inst) begin
            inst_count_d = inst_count_q + CW'(1);
        end else if (!grant_inst && done_inst) begin
            inst_count_d = inst_count_q - CW'(1);
        end
    end

    always_comb begin
        data_count_d = data_count_q;
        if (grant_data && !done_data) begin
            data_count_d = data_count_q + CW'(1);
        end else if (!grant_data && done_data) begin
            data_count_d = data_count_q - CW'(1);
        end
    end

    assign error_d = error_q || err_now;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            arid_q       <= '0;
            araddr_q     <= '0;
            arsize_q     <= '0;
            arvalid_q    <= 1'b0;
            last_grant_q <= LastInst;
            inst_count_q <= '0;
            data_count_q <= '0;
            error_q      <= 1'b0;
        end else begin
            arid_q       <= arid_d;
            araddr_q     <= araddr_d;
            arsize_q     <= arsize_d;
            arvalid_q    <= arvalid_d;
            last_grant_q <= last_grant_d;
            inst_count_q <= inst_count_d;
            data_count_q <= data_count_d;
            error_q      <= error_d;
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed testbench for axi_read_arbiter (MAX_OUTSTANDING=2, INST_ID=0, DATA_ID=1).
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_axi_read_arbiter;

    logic        clock;
    logic        reset;
    logic        inst_req, data_req;
    logic [31:0] inst_addr, data_addr;
    logic [1:0]  inst_size, data_size;
    logic        inst_addr_ok, data_addr_ok;
    logic        inst_data_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        write_pending;
    logic [31:0] write_address;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic        error;

    int checks = 0;
    int errors = 0;

    axi_read_arbiter #(
        .MAX_OUTSTANDING(2),
        .INST_ID        (4'd0),
        .DATA_ID        (4'd1)
    ) dut (
        .clock                  (clock),
        .reset                  (reset),
        .inst_req               (inst_req),
        .inst_addr              (inst_addr),
        .inst_size              (inst_size),
        .inst_addr_ok           (inst_addr_ok),
        .inst_data_ok           (inst_data_ok),
        .inst_rdata             (inst_rdata),
        .data_req               (data_req),
        .data_addr              (data_addr),
        .data_size              (data_size),
        .data_addr_ok           (data_addr_ok),
        .data_data_ok           (data_data_ok),
        .data_rdata             (data_rdata),
        .write_pending          (write_pending),
        .write_address          (write_address),
        .axi_read_address_id    (arid),
        .axi_read_address       (araddr),
        .axi_read_address_length(arlen),
        .axi_read_address_size  (arsize),
        .axi_read_address_burst (arburst),
        .axi_read_address_valid (arvalid),
        .axi_read_address_ready (arready),
        .axi_read_data_id       (rid),
        .axi_read_data          (rdata),
        .axi_read_data_response (rresp),
        .axi_read_data_last     (rlast),
        .axi_read_data_valid    (rvalid),
        .axi_read_data_ready    (rready),
        .error                  (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Drive a single last beat for one cycle, then return with R idle.
    task automatic drain_beat(input logic [3:0] id);
        rvalid = 1'b1;
        rid    = id;
        rdata  = 32'h0;
        rresp  = 2'b00;
        rlast  = 1'b1;
        next_cycle();
        rvalid = 1'b0;
    endtask

    logic [5:0] exp_d_tab;
    logic [5:0] exp_i_tab;

    initial begin
        reset = 1'b1;
        inst_req = 1'b0; data_req = 1'b0;
        inst_addr = '0;  data_addr = '0;
        inst_size = '0;  data_size = '0;
        write_pending = 1'b0; write_address = '0;
        arready = 1'b0;
        rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;

        // Reset values
        #2;
        check("rst_arvalid", {31'b0, arvalid}, 32'd0);
        check("rst_araddr", araddr, 32'd0);
        check("rst_rready", {31'b0, rready}, 32'd0);
        check("rst_error", {31'b0, error}, 32'd0);
        next_cycle();
        reset = 1'b0;

        // Single instruction read
        inst_req = 1'b1; inst_addr = 32'h1FC0_0000; inst_size = 2'd2; arready = 1'b1;
        #1;
        check("t1_inst_addr_ok", {31'b0, inst_addr_ok}, 32'd1);
        check("t1_data_addr_ok", {31'b0, data_addr_ok}, 32'd0);
        next_cycle();
        inst_req = 1'b0;
        #1;
        check("t1_arvalid", {31'b0, arvalid}, 32'd1);
        check("t1_arid", {28'b0, arid}, 32'd0);
        check("t1_araddr", araddr, 32'h1FC0_0000);
        check("t1_arsize", {29'b0, arsize}, 32'd2);
        check("t1_arlen", {24'b0, arlen}, 32'd0);
        check("t1_arburst", {30'b0, arburst}, 32'd1);
        check("t1_rready", {31'b0, rready}, 32'd1);
        next_cycle();
        #1;
        check("t1_arvalid_drop", {31'b0, arvalid}, 32'd0);
        rvalid = 1'b1; rid = 4'd0; rdata = 32'hDEAD_BEEF; rlast = 1'b1; rresp = 2'b00;
        #1;
        check("t1_inst_data_ok", {31'b0, inst_data_ok}, 32'd1);
        check("t1_data_data_ok", {31'b0, data_data_ok}, 32'd0);
        check("t1_inst_rdata", inst_rdata, 32'hDEAD_BEEF);
        next_cycle();
        rvalid = 1'b0;

        // Round-robin with both requesting; MAX=2 caps each at two grants.
        // A leftover inst count would cut inst to one grant here.
        inst_req = 1'b1; inst_addr = 32'h0000_2000; inst_size = 2'd2;
        data_req = 1'b1; data_addr = 32'h0000_1000; data_size = 2'd2;
        exp_d_tab = 6'b000101;
        exp_i_tab = 6'b001010;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("rr_data_ok_%0d", i), {31'b0, data_addr_ok}, {31'b0, exp_d_tab[i]});
            check($sformatf("rr_inst_ok_%0d", i), {31'b0, inst_addr_ok}, {31'b0, exp_i_tab[i]});
            if (i == 1) check("rr_arid_data", {28'b0, arid}, 32'd1);
            if (i == 2) check("rr_arid_inst", {28'b0, arid}, 32'd0);
            next_cycle();
        end
        inst_req = 1'b0;

        // Out-of-order return: data beat first. Same-cycle completion does not unblock.
        rvalid = 1'b1; rid = 4'd1; rdata = 32'h1111_1111; rlast = 1'b1;
        #1;
        check("ooo_data_data_ok", {31'b0, data_data_ok}, 32'd1);
        check("ooo_inst_data_ok0", {31'b0, inst_data_ok}, 32'd0);
        check("ooo_data_rdata", data_rdata, 32'h1111_1111);
        check("ooo_data_full_same", {31'b0, data_addr_ok}, 32'd0);
        next_cycle();
        rvalid = 1'b0;
        #1;
        check("ooo_data_unblock", {31'b0, data_addr_ok}, 32'd1);
        next_cycle();
        data_req = 1'b0;
        inst_req = 1'b1;
        rvalid = 1'b1; rid = 4'd0; rdata = 32'h2222_2222; rlast = 1'b1;
        #1;
        check("ooo_inst_data_ok", {31'b0, inst_data_ok}, 32'd1);
        check("ooo_data_data_ok0", {31'b0, data_data_ok}, 32'd0);
        check("ooo_inst_rdata", inst_rdata, 32'h2222_2222);
        check("ooo_inst_full_same", {31'b0, inst_addr_ok}, 32'd0);
        next_cycle();
        rvalid = 1'b0;
        #1;
        check("ooo_inst_unblock", {31'b0, inst_addr_ok}, 32'd1);
        next_cycle();
        inst_req = 1'b0;
        drain_beat(4'd1);
        drain_beat(4'd0);
        drain_beat(4'd1);
        drain_beat(4'd0);

        // AR stall: outputs hold, no accepts; raising ARREADY grants same cycle.
        arready = 1'b0;
        inst_req = 1'b1; inst_addr = 32'h0000_3000; inst_size = 2'd1;
        #1;
        check("st_first_ok", {31'b0, inst_addr_ok}, 32'd1);
        next_cycle();
        inst_addr = 32'h0000_4000; inst_size = 2'd2;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("st_araddr_%0d", k), araddr, 32'h0000_3000);
            check($sformatf("st_arsize_%0d", k), {29'b0, arsize}, 32'd1);
            check($sformatf("st_arvalid_%0d", k), {31'b0, arvalid}, 32'd1);
            check($sformatf("st_no_ok_%0d", k), {31'b0, inst_addr_ok}, 32'd0);
            next_cycle();
        end
        arready = 1'b1;
        #1;
        check("st_release_ok", {31'b0, inst_addr_ok}, 32'd1);
        next_cycle();
        inst_req = 1'b0;
        #1;
        check("st_next_araddr", araddr, 32'h0000_4000);
        check("st_next_arsize", {29'b0, arsize}, 32'd2);
        drain_beat(4'd0);
        drain_beat(4'd0);

        // Write hazard blocks data, inst proceeds; clearing grants data same cycle.
        write_pending = 1'b1; write_address = 32'h8000_0010;
        data_req = 1'b1; data_addr = 32'h8000_0012; data_size = 2'd0;
        inst_req = 1'b1; inst_addr = 32'h8000_0100; inst_size = 2'd2;
        #1;
        check("hz_data_blocked", {31'b0, data_addr_ok}, 32'd0);
        check("hz_inst_ok", {31'b0, inst_addr_ok}, 32'd1);
        next_cycle();
        inst_req = 1'b0;
        #1;
        check("hz_data_blocked2", {31'b0, data_addr_ok}, 32'd0);
        check("hz_araddr_inst", araddr, 32'h8000_0100);
        next_cycle();
        write_pending = 1'b0;
        #1;
        check("hz_data_clear_ok", {31'b0, data_addr_ok}, 32'd1);
        next_cycle();
        data_req = 1'b0;
        #1;
        check("hz_araddr_data", araddr, 32'h8000_0012);
        check("hz_arid_data", {28'b0, arid}, 32'd1);
        check("hz_arsize_data", {29'b0, arsize}, 32'd0);
        drain_beat(4'd0);
        drain_beat(4'd1);

        // Error: unknown RID, then id0 with nothing outstanding.
        #1;
        check("er_clean", {31'b0, error}, 32'd0);
        rvalid = 1'b1; rid = 4'd7; rdata = 32'h0; rlast = 1'b1; rresp = 2'b00;
        #1;
        check("er_id7_inst_ok", {31'b0, inst_data_ok}, 32'd0);
        check("er_id7_data_ok", {31'b0, data_data_ok}, 32'd0);
        next_cycle();
        rid = 4'd0; rdata = 32'h3333_3333;
        #1;
        check("er_set", {31'b0, error}, 32'd1);
        check("er_zero_cnt_ok", {31'b0, inst_data_ok}, 32'd1);
        next_cycle();
        rvalid = 1'b0;
        inst_req = 1'b1; inst_addr = 32'h0000_0100;
        #1;
        check("er_no_underflow", {31'b0, inst_addr_ok}, 32'd1);
        check("er_sticky", {31'b0, error}, 32'd1);
        next_cycle();
        inst_req = 1'b0;

        // Reset mid-operation clears error and AR state.
        reset = 1'b1;
        #1;
        check("mr_error", {31'b0, error}, 32'd0);
        check("mr_arvalid", {31'b0, arvalid}, 32'd0);
        check("mr_rready", {31'b0, rready}, 32'd0);
        next_cycle();
        reset = 1'b0;

        // Non-OKAY response: data still delivered, error set next cycle.
        inst_req = 1'b1;
        #1;
        check("rs_grant", {31'b0, inst_addr_ok}, 32'd1);
        next_cycle();
        inst_req = 1'b0;
        rvalid = 1'b1; rid = 4'd0; rdata = 32'h4444_4444; rlast = 1'b1; rresp = 2'b10;
        #1;
        check("rs_data_ok", {31'b0, inst_data_ok}, 32'd1);
        check("rs_rdata", inst_rdata, 32'h4444_4444);
        check("rs_error_pre", {31'b0, error}, 32'd0);
        next_cycle();
        rvalid = 1'b0; rresp = 2'b00;
        #1;
        check("rs_error_set", {31'b0, error}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
